// File: rtl/logic_op_sched_pkg.sv
// rtl/logic_op_sched_pkg.sv - shared opcodes, FSM encoding and id width for logic_op_sched
package logic_op_sched_pkg;

    localparam logic [1:0] OP_XOR  = 2'b00;
    localparam logic [1:0] OP_XNOR = 2'b01;

    localparam int ID_W = 1;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
        ST_RESP = 2'd2
    } state_t;

endpackage

// File: rtl/logic_op_sched_if.sv
// rtl/logic_op_sched_if.sv - two request ports and one response port of logic_op_sched
interface logic_op_sched_if #(
    parameter int WIDTH = 16
);
    logic             req0_valid;
    logic             req0_ready;
    logic [1:0]       req0_op;
    logic [WIDTH-1:0] req0_a;
    logic [WIDTH-1:0] req0_b;

    logic             req1_valid;
    logic             req1_ready;
    logic [1:0]       req1_op;
    logic [WIDTH-1:0] req1_a;
    logic [WIDTH-1:0] req1_b;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [WIDTH-1:0] rsp_data;
    logic             rsp_err;
    logic             rsp_zero;

    // Requesters and response consumer side
    modport master (
        output req0_valid, req0_op, req0_a, req0_b,
        output req1_valid, req1_op, req1_a, req1_b,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_data, rsp_err, rsp_zero
    );

    // Scheduler side
    modport slave (
        input  req0_valid, req0_op, req0_a, req0_b,
        input  req1_valid, req1_op, req1_a, req1_b,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_data, rsp_err, rsp_zero
    );
endinterface

// File: rtl/logic_op_stage.sv
// rtl/logic_op_stage.sv - registered XOR/XNOR stage with illegal-opcode flagging
module logic_op_stage
    import logic_op_sched_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_en,
    input  logic [1:0]       i_op,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic [WIDTH-1:0] o_result,
    output logic             o_err,
    output logic             o_zero
);
    logic [WIDTH-1:0] r_result;
    logic             r_err;
    logic             r_zero;
    logic [WIDTH-1:0] w_xor;

    assign w_xor = i_a ^ i_b;

    // Capture the result only when enabled so it stays stable while the response is held
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_result <= '0;
            r_err    <= 1'b0;
            r_zero   <= 1'b0;
        end else if (i_en) begin
            case (i_op)
                OP_XOR: begin
                    r_result <= w_xor;
                    r_err    <= 1'b0;
                    r_zero   <= (w_xor == '0);
                end
                OP_XNOR: begin
                    r_result <= ~w_xor;
                    r_err    <= 1'b0;
                    r_zero   <= (~w_xor == '0);
                end
                default: begin
                    r_result <= '0;
                    r_err    <= 1'b1;
                    r_zero   <= 1'b1;
                end
            endcase
        end
    end

    assign o_result = r_result;
    assign o_err    = r_err;
    assign o_zero   = r_zero;
endmodule

// File: rtl/logic_op_sched.sv
// rtl/logic_op_sched.sv - round-robin scheduler sharing one logic stage between two requesters
module logic_op_sched
    import logic_op_sched_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    logic_op_sched_if.slave  bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_count
);
    state_t           r_state;
    state_t           w_next;
    logic [ID_W-1:0]  r_last_grant;
    logic [ID_W-1:0]  r_id;
    logic [1:0]       r_op;
    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [CNT_W-1:0] r_done;

    logic [ID_W-1:0]  w_sel;
    logic             w_ready0;
    logic             w_ready1;
    logic             w_rsp_valid;
    logic             w_busy;
    logic             w_req_hs;
    logic             w_rsp_hs;
    logic [WIDTH-1:0] w_result;
    logic             w_err;
    logic             w_zero;

    // Lone requester wins outright; on contention the one not granted last time wins
    assign w_sel    = (bus.req0_valid && bus.req1_valid) ? ~r_last_grant : bus.req1_valid;
    assign w_req_hs = w_ready0 | w_ready1;
    assign w_rsp_hs = w_rsp_valid & bus.rsp_ready;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_req_hs) w_next = ST_EXEC;
            ST_EXEC: w_next = ST_RESP;
            ST_RESP: if (bus.rsp_ready) w_next = ST_IDLE;
            default: w_next = ST_IDLE;
        endcase
    end

    // Output decode: ready only in IDLE, response valid only in RESP
    always_comb begin
        w_ready0    = 1'b0;
        w_ready1    = 1'b0;
        w_rsp_valid = 1'b0;
        w_busy      = 1'b1;
        case (r_state)
            ST_IDLE: begin
                w_busy   = 1'b0;
                w_ready0 = bus.req0_valid && (w_sel == '0);
                w_ready1 = bus.req1_valid && (w_sel != '0);
            end
            ST_RESP: w_rsp_valid = 1'b1;
            default: ;
        endcase
    end

    // Latch the granted request so later input changes cannot disturb the in-flight op
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_id <= '0;
            r_op <= '0;
            r_a  <= '0;
            r_b  <= '0;
        end else if (w_req_hs) begin
            r_id <= w_sel;
            r_op <= (w_sel != '0) ? bus.req1_op : bus.req0_op;
            r_a  <= (w_sel != '0) ? bus.req1_a  : bus.req0_a;
            r_b  <= (w_sel != '0) ? bus.req1_b  : bus.req0_b;
        end
    end

    // Round-robin pointer and saturating completion count advance on response handshake
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_grant <= '1;
            r_done       <= '0;
        end else if (w_rsp_hs) begin
            r_last_grant <= r_id;
            if (r_done != '1) r_done <= r_done + CNT_W'(1);
        end
    end

    logic_op_stage #(.WIDTH(WIDTH)) u_stage (
        .clk      (clk),
        .rst      (rst),
        .i_en     (r_state == ST_EXEC),
        .i_op     (r_op),
        .i_a      (r_a),
        .i_b      (r_b),
        .o_result (w_result),
        .o_err    (w_err),
        .o_zero   (w_zero)
    );

    assign bus.req0_ready = w_ready0;
    assign bus.req1_ready = w_ready1;
    assign bus.rsp_valid  = w_rsp_valid;
    assign bus.rsp_id     = r_id;
    assign bus.rsp_data   = w_result;
    assign bus.rsp_err    = w_err;
    assign bus.rsp_zero   = w_zero;
    assign busy           = w_busy;
    assign done_count     = r_done;
endmodule

// File: tb/tb_logic_op_sched.sv
// tb/tb_logic_op_sched.sv - directed self-checking bench for logic_op_sched
module tb_logic_op_sched;
    logic        clk;
    logic        rst;
    logic        busy;
    logic [15:0] done_count;
    logic        s_busy;
    logic [1:0]  s_done;
    int          errors;
    int          checks;

    logic_op_sched_if #(.WIDTH(16)) bus ();
    logic_op_sched_if #(.WIDTH(16)) bs ();

    logic_op_sched #(.WIDTH(16), .CNT_W(16)) dut (
        .clk        (clk),
        .rst        (rst),
        .bus        (bus),
        .busy       (busy),
        .done_count (done_count)
    );

    logic_op_sched #(.WIDTH(16), .CNT_W(2)) dut_sat (
        .clk        (clk),
        .rst        (rst),
        .bus        (bs),
        .busy       (s_busy),
        .done_count (s_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Present one request, check its ready, let it be accepted, then withdraw it
    task automatic do_req(input int who, input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
        if (who == 0) begin
            bus.req0_valid = 1'b1; bus.req0_op = op; bus.req0_a = a; bus.req0_b = b;
        end else begin
            bus.req1_valid = 1'b1; bus.req1_op = op; bus.req1_a = a; bus.req1_b = b;
        end
        #1;
        chk("req0_ready", bus.req0_ready, (who == 0));
        chk("req1_ready", bus.req1_ready, (who == 1));
        step();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    task automatic chk_rsp(input logic id, input logic [15:0] data, input logic err, input logic zero);
        chk("rsp_valid", bus.rsp_valid, 1'b1);
        chk("rsp_id",    bus.rsp_id,    id);
        chk("rsp_data",  bus.rsp_data,  data);
        chk("rsp_err",   bus.rsp_err,   err);
        chk("rsp_zero",  bus.rsp_zero,  zero);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rst = 1'b1;
        bus.req0_valid = 0; bus.req0_op = 0; bus.req0_a = 0; bus.req0_b = 0;
        bus.req1_valid = 0; bus.req1_op = 0; bus.req1_a = 0; bus.req1_b = 0;
        bus.rsp_ready  = 0;
        bs.req0_valid  = 0; bs.req0_op  = 0; bs.req0_a  = 0; bs.req0_b  = 0;
        bs.req1_valid  = 0; bs.req1_op  = 0; bs.req1_a  = 0; bs.req1_b  = 0;
        bs.rsp_ready   = 0;
        step();
        step();

        // Reset values
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_id",    bus.rsp_id,    0);
        chk("rst_rsp_data",  bus.rsp_data,  0);
        chk("rst_rsp_err",   bus.rsp_err,   0);
        chk("rst_rsp_zero",  bus.rsp_zero,  0);
        chk("rst_busy",      busy,          0);
        chk("rst_done",      done_count,    0);
        rst = 1'b0;
        step();

        // Single XOR: F0F0 ^ 0FF0 = FF00
        bus.rsp_ready = 1'b1;
        do_req(0, 2'b00, 16'hF0F0, 16'h0FF0);
        #1;
        chk("exec_busy",      busy,          1);
        chk("exec_rsp_valid", bus.rsp_valid, 0);
        step();
        chk_rsp(1'b0, 16'hFF00, 1'b0, 1'b0);
        chk("xor_done_before", done_count, 0);
        step();
        chk("xor_rsp_drop", bus.rsp_valid, 0);
        chk("xor_idle",     busy,          0);
        chk("xor_done",     done_count,    1);

        // XNOR giving zero: ~(1234 ^ EDCB) = 0000
        do_req(1, 2'b01, 16'h1234, 16'hEDCB);
        step();
        chk_rsp(1'b1, 16'h0000, 1'b0, 1'b1);
        step();
        chk("xnor_done", done_count, 2);

        // Contention from reset: grants 0,1,0,1 every 3 cycles
        rst = 1'b1;
        #1;
        chk("rst2_done", done_count, 0);
        step();
        rst = 1'b0;
        bus.req0_valid = 1'b1; bus.req0_op = 2'b00; bus.req0_a = 16'h00FF; bus.req0_b = 16'h0F0F;
        bus.req1_valid = 1'b1; bus.req1_op = 2'b01; bus.req1_a = 16'hAAAA; bus.req1_b = 16'h5555;
        #1;
        for (int c = 0; c < 12; c++) begin
            chk("cont_ready0",    bus.req0_ready, (c % 6 == 0));
            chk("cont_ready1",    bus.req1_ready, (c % 6 == 3));
            chk("cont_rsp_valid", bus.rsp_valid,  (c % 3 == 2));
            if (c % 3 == 2) begin
                chk("cont_rsp_id",   bus.rsp_id,   ((c / 3) % 2));
                chk("cont_rsp_data", bus.rsp_data, (((c / 3) % 2) == 1) ? 32'h0000 : 32'h0FF0);
            end
            step();
        end
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
        #1;
        chk("cont_done", done_count, 4);
        chk("cont_idle", busy,       0);

        // Backpressure; operands changed after acceptance must not matter
        bus.rsp_ready = 1'b0;
        do_req(0, 2'b00, 16'h1111, 16'h2222);
        bus.req0_valid = 1'b1; bus.req0_op = 2'b01; bus.req0_a = 16'hFFFF; bus.req0_b = 16'hFFFF;
        step();
        for (int c = 0; c < 5; c++) begin
            chk_rsp(1'b0, 16'h3333, 1'b0, 1'b0);
            chk("bp_ready0", bus.req0_ready, 0);
            chk("bp_ready1", bus.req1_ready, 0);
            chk("bp_busy",   busy,           1);
            step();
        end
        bus.rsp_ready = 1'b1;
        step();
        chk("bp_rsp_drop", bus.rsp_valid,  0);
        chk("bp_idle",     busy,           0);
        chk("bp_done",     done_count,     5);
        chk("bp_ready0_i", bus.req0_ready, 1);
        bus.req0_valid = 1'b0;

        // Illegal opcode
        do_req(0, 2'b11, 16'hFFFF, 16'h0000);
        step();
        chk_rsp(1'b0, 16'h0000, 1'b1, 1'b1);
        step();
        chk("ill_done", done_count, 6);

        // Reset during EXEC discards the op
        do_req(0, 2'b00, 16'h0001, 16'h0002);
        chk("mid_busy", busy, 1);
        rst = 1'b1;
        #1;
        chk("mid_rsp_valid", bus.rsp_valid, 0);
        chk("mid_busy_rst",  busy,          0);
        chk("mid_done",      done_count,    0);
        chk("mid_rsp_data",  bus.rsp_data,  0);
        step();
        rst = 1'b0;
        step();
        chk("post_rsp_valid", bus.rsp_valid, 0);
        do_req(1, 2'b00, 16'h00F0, 16'h000F);
        step();
        chk_rsp(1'b1, 16'h00FF, 1'b0, 1'b0);
        step();
        chk("post_done", done_count, 1);

        // Saturating counter on a 2-bit instance
        bs.rsp_ready  = 1'b1;
        bs.req0_valid = 1'b1;
        bs.req0_a     = 16'h0F0F;
        bs.req0_b     = 16'h00FF;
        for (int c = 0; c < 6; c++) step();
        chk("sat_two",   s_done, 2);
        for (int c = 0; c < 3; c++) step();
        chk("sat_three", s_done, 3);
        for (int c = 0; c < 6; c++) step();
        chk("sat_hold",  s_done, 3);
        chk("sat_data",  bs.rsp_data, 16'h0FF0);
        bs.req0_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
